cic_decimator_ctrl: RTL and testbench
=====================================

CIC_DECIMATOR_CTRL -- requirements
Module: cic_decimator_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: I/Q sample width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the output-count and discard counters.
REQ-003 SHALL have parameter CLR_CYCLES, default 4: number of cycles o_dec_reset is held when a run starts.
REQ-004 SHALL have ports; one clock; reset is synchronous and active-high:
- i_clock, in, 1: clock.
- i_reset, in, 1: synchronous active-high reset.
- i_start, in, 1: begin a run (sampled in IDLE only).
- i_stop, in, 1: end the current run early.
- i_num_outputs, in, CNT_WIDTH: outputs to forward per run; 0 means unlimited.
- i_discard, in, CNT_WIDTH: leading decimator outputs to drop (CIC settling).
- i_inph, in, WIDTH: upstream I sample.
- i_quad, in, WIDTH: upstream Q sample.
- i_valid, in, 1: upstream sample valid.
- o_ready, out, 1: upstream may present samples.
- o_dec_inph, out, WIDTH: I sample to the decimator.
- o_dec_quad, out, WIDTH: Q sample to the decimator.
- o_dec_valid, out, 1: decimator input valid.
- o_dec_reset, out, 1: decimator reset.
- i_dec_inph, in, WIDTH: decimator I output.
- i_dec_quad, in, WIDTH: decimator Q output.
- i_dec_valid, in, 1: decimator output valid.
- i_dec_oflow, in, 8: decimator overflow flags, in order {cic_quad_neg, cic_quad_pos, cic_inph_neg, cic_inph_pos, quad_neg, quad_pos, inph_neg, inph_pos}.
- o_inph, out, WIDTH: forwarded I sample.
- o_quad, out, WIDTH: forwarded Q sample.
- o_valid, out, 1: forwarded sample valid.
- o_busy, out, 1: state is not IDLE.
- o_done, out, 1: one-cycle pulse at end of run.
- o_abort, out, 1: one-cycle pulse when a run ends on overflow.
- o_oflow_sticky, out, 8: OR of i_dec_oflow accumulated over the run.

Function
REQ-005 SHALL implement the FSM IDLE -> CLEAR -> RUN -> DONE -> IDLE.
- IDLE: stay until i_start=1.
- CLEAR: last exactly CLR_CYCLES cycles.
- DONE: last exactly one cycle.
REQ-006 On entry to CLEAR, the block SHALL:
- zero the discard and output counters;
- clear o_oflow_sticky;
- latch i_num_outputs and i_discard for the whole run.
REQ-007 o_dec_reset SHALL be 1 throughout CLEAR and 0 in every other state.
REQ-008 o_ready SHALL be 1 only in RUN, combinationally from the state register.
REQ-009 In RUN, i_valid&o_ready SHALL register into o_dec_inph/o_dec_quad/o_dec_valid with 1-cycle latency. In all other states o_dec_valid SHALL be 0.
REQ-010 While the discard count is below the latched i_discard, each i_dec_valid SHALL increment the discard counter and SHALL NOT produce o_valid.
REQ-011 After the discard phase, each i_dec_valid in RUN SHALL drive i_dec_inph/quad to o_inph/o_quad with o_valid=1, registered with 1-cycle latency, and SHALL increment the output counter.
REQ-012 When the forwarded output is number N (N = latched i_num_outputs, N≠0), the FSM SHALL enter DONE on the next cycle. No further o_valid SHALL follow.
REQ-013 i_stop=1 in CLEAR or RUN SHALL move the FSM to DONE next cycle. i_stop in IDLE or DONE SHALL be ignored.
REQ-014 o_done SHALL be 1 for exactly the cycle in DONE.
REQ-015 o_oflow_sticky SHALL OR in i_dec_oflow every cycle in RUN. It SHALL hold its value in DONE and IDLE until the next CLEAR.
REQ-016 Simultaneous events:
- if the Nth output and i_stop coincide, the Nth output is forwarded and DONE is entered once;
- i_start during DONE is ignored.
REQ-017 Counters SHALL saturate at all-ones and SHALL NOT wrap; with N=0 the output counter saturates while forwarding continues.

Reset
REQ-018 i_reset SHALL force IDLE and zero all counters. Output values under reset:
- o_ready, o_dec_valid, o_valid, o_done, o_abort, o_busy = 0;
- o_dec_inph, o_dec_quad, o_inph, o_quad = 0;
- o_oflow_sticky = 0;
- o_dec_reset = 1.
REQ-019 Reset asserted mid-run SHALL abort the run without an o_done pulse.

Configuration
REQ-020 With CIC_CTRL_OFLOW_ABORT_EN defined:
- any nonzero i_dec_oflow in RUN SHALL move the FSM to DONE next cycle;
- o_abort SHALL pulse with o_done;
- the sample that coincides with the overflow is still forwarded.
REQ-021 Without CIC_CTRL_OFLOW_ABORT_EN, o_abort SHALL be tied to 0 and overflows SHALL only update o_oflow_sticky.

Structure
REQ-022 A shared package cic_ctrl_pkg SHALL hold:
- the state enum (IDLE, CLEAR, RUN, DONE);
- the oflow bit-index constants;
- CLR_CYCLES_DEFAULT.
REQ-023 The block SHALL be a single module without sub-modules; it instantiates no cic_decimator (that is connected at the next level up).

Verification
REQ-024 Bench SHALL cover these scenarios:
- No i_start, 1000 cycles -> o_busy=0, o_valid=0, o_dec_reset=1, o_dec_valid=0 throughout.
- start, N=10, discard=3, 15 i_dec_valid pulses -> first 3 dropped, exactly 10 o_valid, o_done one cycle after the 10th output, o_ready=0 afterwards.
- start, then i_stop asserted in cycle 2 of CLEAR -> o_dec_reset high 2 cycles, o_done pulse, zero o_valid.
- RUN with i_dec_oflow=8'h04 for one cycle -> o_oflow_sticky=8'h04 held after DONE. With the macro: o_abort=1 coincident with o_done. Without the macro: run continues to N.
- i_reset asserted mid-RUN after 5 outputs -> IDLE, no o_done; restart with N=4 -> exactly 4 outputs.
- N=0 with 70000 decimator outputs -> all forwarded, no DONE until i_stop.

Source files
------------

// File: rtl/cic_ctrl_pkg.sv
// Shared types and constants for the CIC decimator run controller.
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int OFLOW_W = 8;

  // Bit positions inside the decimator overflow flag vector.
  localparam int OFLOW_INPH_POS     = 0;
  localparam int OFLOW_INPH_NEG     = 1;
  localparam int OFLOW_QUAD_POS     = 2;
  localparam int OFLOW_QUAD_NEG     = 3;
  localparam int OFLOW_CIC_INPH_POS = 4;
  localparam int OFLOW_CIC_INPH_NEG = 5;
  localparam int OFLOW_CIC_QUAD_POS = 6;
  localparam int OFLOW_CIC_QUAD_NEG = 7;

  localparam int CLR_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/cic_decimator_ctrl.sv
// Run controller around a CIC decimator: clears it, feeds it, drops settling outputs
// and forwards N results. Define CIC_CTRL_OFLOW_ABORT_EN to end a run on overflow.
module cic_decimator_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int CLR_CYCLES = CLR_CYCLES_DEFAULT
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [CNT_WIDTH-1:0] i_num_outputs,
  input  logic [CNT_WIDTH-1:0] i_discard,
  input  logic [WIDTH-1:0]     i_inph,
  input  logic [WIDTH-1:0]     i_quad,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [WIDTH-1:0]     o_dec_inph,
  output logic [WIDTH-1:0]     o_dec_quad,
  output logic                 o_dec_valid,
  output logic                 o_dec_reset,
  input  logic [WIDTH-1:0]     i_dec_inph,
  input  logic [WIDTH-1:0]     i_dec_quad,
  input  logic                 i_dec_valid,
  input  logic [OFLOW_W-1:0]   i_dec_oflow,
  output logic [WIDTH-1:0]     o_inph,
  output logic [WIDTH-1:0]     o_quad,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_abort,
  output logic [OFLOW_W-1:0]   o_oflow_sticky
);

  localparam int                   CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t               state;
  logic [CLR_W-1:0]     clr_cnt;
  logic [CNT_WIDTH-1:0] disc_cnt;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic [CNT_WIDTH-1:0] num_lat;
  logic [CNT_WIDTH-1:0] disc_lat;

  logic discarding;
  logic nth;
  logic oflow_hit;
  logic run_end;

  assign o_ready = (state == RUN);

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    discarding = (disc_cnt < disc_lat);
    nth        = i_dec_valid && !discarding && (num_lat != '0) &&
                 (out_cnt == num_lat - CNT_ONE);
`ifdef CIC_CTRL_OFLOW_ABORT_EN
    oflow_hit  = |i_dec_oflow;
`else
    oflow_hit  = 1'b0;
`endif
    run_end    = i_stop || nth || oflow_hit;
  end

`ifdef CIC_CTRL_OFLOW_ABORT_EN
  logic abort_r;
  assign o_abort = abort_r;
`else
  assign o_abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= IDLE;
      clr_cnt        <= '0;
      disc_cnt       <= '0;
      out_cnt        <= '0;
      num_lat        <= '0;
      disc_lat       <= '0;
      o_dec_inph     <= '0;
      o_dec_quad     <= '0;
      o_dec_valid    <= 1'b0;
      o_dec_reset    <= 1'b1;
      o_inph         <= '0;
      o_quad         <= '0;
      o_valid        <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_oflow_sticky <= '0;
`ifdef CIC_CTRL_OFLOW_ABORT_EN
      abort_r        <= 1'b0;
`endif
    end else begin
      o_dec_valid <= 1'b0;
      o_dec_reset <= 1'b0;
      o_valid     <= 1'b0;
      o_done      <= 1'b0;
`ifdef CIC_CTRL_OFLOW_ABORT_EN
      abort_r     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (i_start) begin
            state          <= CLEAR;
            clr_cnt        <= '0;
            disc_cnt       <= '0;
            out_cnt        <= '0;
            num_lat        <= i_num_outputs;
            disc_lat       <= i_discard;
            o_oflow_sticky <= '0;
            o_dec_reset    <= 1'b1;
            o_busy         <= 1'b1;
          end
        end
        CLEAR: begin
          if (i_stop) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else if (clr_cnt == CLR_LAST) begin
            state <= RUN;
          end else begin
            clr_cnt     <= clr_cnt + CLR_W'(1);
            o_dec_reset <= 1'b1;
          end
        end
        RUN: begin
          o_oflow_sticky <= o_oflow_sticky | i_dec_oflow;
          // Samples accepted on the final RUN cycle are dropped: the decimator is cleared next run.
          if (i_valid && !run_end) begin
            o_dec_valid <= 1'b1;
            o_dec_inph  <= i_inph;
            o_dec_quad  <= i_quad;
          end
          if (i_dec_valid) begin
            if (discarding) begin
              if (disc_cnt != CNT_MAX) disc_cnt <= disc_cnt + CNT_ONE;
            end else begin
              o_valid <= 1'b1;
              o_inph  <= i_dec_inph;
              o_quad  <= i_dec_quad;
              if (out_cnt != CNT_MAX) out_cnt <= out_cnt + CNT_ONE;
            end
          end
          if (run_end) begin
            state  <= DONE;
            o_done <= 1'b1;
`ifdef CIC_CTRL_OFLOW_ABORT_EN
            abort_r <= oflow_hit;
`endif
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_decimator_ctrl.sv
// Scoreboard bench for cic_decimator_ctrl; expectations follow CIC_CTRL_OFLOW_ABORT_EN.
module tb_cic_decimator_ctrl;
  import cic_ctrl_pkg::*;

  localparam int WIDTH      = 16;
  localparam int CNT_WIDTH  = 16;
  localparam int CLR_CYCLES = 4;

  logic                 i_clock = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_start = 1'b0;
  logic                 i_stop = 1'b0;
  logic [CNT_WIDTH-1:0] i_num_outputs = '0;
  logic [CNT_WIDTH-1:0] i_discard = '0;
  logic [WIDTH-1:0]     i_inph = '0;
  logic [WIDTH-1:0]     i_quad = '0;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic [WIDTH-1:0]     o_dec_inph;
  logic [WIDTH-1:0]     o_dec_quad;
  logic                 o_dec_valid;
  logic                 o_dec_reset;
  logic [WIDTH-1:0]     i_dec_inph = '0;
  logic [WIDTH-1:0]     i_dec_quad = '0;
  logic                 i_dec_valid = 1'b0;
  logic [7:0]           i_dec_oflow = '0;
  logic [WIDTH-1:0]     o_inph;
  logic [WIDTH-1:0]     o_quad;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_abort;
  logic [7:0]           o_oflow_sticky;

  always #5 i_clock = ~i_clock;

  cic_decimator_ctrl #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_num_outputs (i_num_outputs),
    .i_discard     (i_discard),
    .i_inph        (i_inph),
    .i_quad        (i_quad),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_dec_inph    (o_dec_inph),
    .o_dec_quad    (o_dec_quad),
    .o_dec_valid   (o_dec_valid),
    .o_dec_reset   (o_dec_reset),
    .i_dec_inph    (i_dec_inph),
    .i_dec_quad    (i_dec_quad),
    .i_dec_valid   (i_dec_valid),
    .i_dec_oflow   (i_dec_oflow),
    .o_inph        (o_inph),
    .o_quad        (o_quad),
    .o_valid       (o_valid),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_abort       (o_abort),
    .o_oflow_sticky(o_oflow_sticky)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard of forwarded {I,Q} pairs plus event counters.
  logic [2*WIDTH-1:0] sb_q[$];
  int cyc = 0;
  int valid_cnt, done_cnt, abort_cnt, dec_rst_cnt, done_cyc, abort_cyc;

  always @(posedge i_clock) cyc <= cyc + 1;

  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_valid) begin
        valid_cnt++;
        if (sb_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("fwd_data", {o_inph, o_quad}, sb_q.pop_front());
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_abort) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
      if (o_dec_reset) dec_rst_cnt++;
    end
  end

  // Reference model of the run in progress.
  bit                   m_run = 1'b0;
  logic [CNT_WIDTH-1:0] m_num, m_disc;
  int                   m_drop, m_fwd, last_fwd_cyc;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_stats();
    valid_cnt = 0; done_cnt = 0; abort_cnt = 0; dec_rst_cnt = 0;
    done_cyc = -1; abort_cyc = -2;
  endtask

  task automatic start_only(input logic [CNT_WIDTH-1:0] n, input logic [CNT_WIDTH-1:0] d);
    clear_stats();
    m_num = n; m_disc = d; m_drop = 0; m_fwd = 0; m_run = 1'b0;
    i_num_outputs = n; i_discard = d; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_num_outputs = '0; i_discard = '0;
    check("clear_dec_reset", o_dec_reset, 1);
    check("clear_busy", o_busy, 1);
    check("clear_sticky", o_oflow_sticky, 0);
  endtask

  task automatic clear_to_run();
    i_valid = 1'b1; i_inph = 16'hdead; i_quad = 16'hbeef;
    for (int k = 0; k < CLR_CYCLES; k++) begin
      tick();
      check("clear_dec_valid", o_dec_valid, 0);
      check("clear_ready", o_ready, (k == CLR_CYCLES - 1) ? 1 : 0);
    end
    i_valid = 1'b0;
    check("run_dec_reset", o_dec_reset, 0);
    m_run = 1'b1;
  endtask

  task automatic dec_pulse(input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dq,
                           input logic [7:0] of, input bit stop = 1'b0);
    i_dec_valid = 1'b1; i_dec_inph = di; i_dec_quad = dq; i_dec_oflow = of; i_stop = stop;
    if (m_run) begin
      if (m_drop < int'(m_disc)) m_drop++;
      else begin
        sb_q.push_back({di, dq});
        m_fwd++;
        last_fwd_cyc = cyc;
        if (m_num != 0 && m_fwd == int'(m_num)) m_run = 1'b0;
      end
`ifdef CIC_CTRL_OFLOW_ABORT_EN
      if (of != 0) m_run = 1'b0;
`endif
      if (stop) m_run = 1'b0;
    end
    tick();
    i_dec_valid = 1'b0; i_dec_oflow = '0; i_stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (done_cnt > 0) seen = 1'b1;
      else tick();
    end
    check(tag, seen, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_busy, seen_valid, seen_dvalid, seen_drst_low;
    logic [WIDTH-1:0] vi, vq;
    logic [7:0] of;

    // Held in reset, no start: outputs stay at reset values throughout.
    seen_busy = 0; seen_valid = 0; seen_dvalid = 0; seen_drst_low = 0;
    for (int k = 0; k < 1000; k++) begin
      i_valid = 1'(k); i_dec_valid = 1'(k >> 1); i_dec_oflow = 8'($urandom); i_stop = 1'(k >> 2);
      tick();
      seen_busy |= o_busy; seen_valid |= o_valid; seen_dvalid |= o_dec_valid;
      seen_drst_low |= !o_dec_reset;
    end
    check("rst_busy", seen_busy, 0);
    check("rst_valid", seen_valid, 0);
    check("rst_dec_valid", seen_dvalid, 0);
    check("rst_dec_reset_low", seen_drst_low, 0);
    check("rst_ready", o_ready, 0);
    check("rst_done_abort", {o_done, o_abort}, 0);
    check("rst_data", {o_inph, o_quad, o_dec_inph, o_dec_quad}, 0);
    check("rst_sticky", o_oflow_sticky, 0);
    i_reset = 1'b0; i_valid = 0; i_dec_valid = 0; i_stop = 0; i_dec_oflow = 8'hff;
    tick(); tick();
    i_dec_oflow = '0;
    check("idle_dec_reset", o_dec_reset, 0);
    check("idle_busy", o_busy, 0);
    check("idle_sticky", o_oflow_sticky, 0);

    // N=10, discard=3, 15 decimator outputs.
    start_only(16'd10, 16'd3);
    clear_to_run();
    for (int k = 0; k < 3; k++) begin
      vi = 16'h1000 + 16'(k); vq = 16'h2000 + 16'(k);
      i_valid = 1'b1; i_inph = vi; i_quad = vq;
      tick();
      check("dec_valid", o_dec_valid, 1);
      check("dec_data", {o_dec_inph, o_dec_quad}, {vi, vq});
    end
    i_valid = 1'b0;
    tick();
    check("dec_valid_idle", o_dec_valid, 0);
    for (int k = 0; k < 15; k++) dec_pulse(16'($urandom), 16'($urandom), 8'h00);
    tick(); tick();
    check("n10_valid_cnt", valid_cnt, 10);
    check("n10_done_cnt", done_cnt, 1);
    check("n10_done_cyc", done_cyc, last_fwd_cyc + 1);
    check("n10_ready_after", o_ready, 0);
    check("n10_dec_reset_cycles", dec_rst_cnt, CLR_CYCLES);
    check("n10_busy_after", o_busy, 0);

    // Stop in the second CLEAR cycle; start during DONE is ignored.
    start_only(16'd10, 16'd0);
    i_dec_valid = 1'b1;
    tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0; i_dec_valid = 1'b0; i_start = 1'b1;
    check("stop_done_pulse", o_done, 1);
    tick();
    i_start = 1'b0;
    tick();
    check("stop_busy", o_busy, 0);
    check("stop_dec_reset_cycles", dec_rst_cnt, 2);
    check("stop_done_cnt", done_cnt, 1);
    check("stop_valid_cnt", valid_cnt, 0);

    // One-cycle overflow 8'h04 on the third output.
    start_only(16'd6, 16'd0);
    clear_to_run();
    for (int k = 0; k < 8; k++) begin
      of = (k == 2) ? 8'h04 : (m_run ? 8'h00 : 8'h01);
      dec_pulse(16'h0300 + 16'(k), 16'h0400 + 16'(k), of);
    end
    i_dec_oflow = 8'h01;
    tick(); tick();
    i_dec_oflow = '0;
    check("oflow_sticky", o_oflow_sticky, 8'h04);
    check("oflow_done_cnt", done_cnt, 1);
`ifdef CIC_CTRL_OFLOW_ABORT_EN
    check("oflow_valid_cnt", valid_cnt, 3);
    check("oflow_abort_cnt", abort_cnt, 1);
    check("oflow_abort_cyc", abort_cyc, done_cyc);
`else
    check("oflow_valid_cnt", valid_cnt, 6);
    check("oflow_abort_cnt", abort_cnt, 0);
`endif

    // Reset mid-run after 5 outputs, then a clean N=4 run.
    start_only(16'd20, 16'd0);
    clear_to_run();
    for (int k = 0; k < 5; k++) dec_pulse(16'($urandom), 16'($urandom), 8'h00);
    tick();
    i_reset = 1'b1; m_run = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    tick();
    check("midrst_busy", o_busy, 0);
    check("midrst_done_cnt", done_cnt, 0);
    check("midrst_valid_cnt", valid_cnt, 5);
    start_only(16'd4, 16'd0);
    clear_to_run();
    for (int k = 0; k < 8; k++) dec_pulse(16'($urandom), 16'($urandom), 8'h00);
    tick();
    check("restart_valid_cnt", valid_cnt, 4);
    check("restart_done_cnt", done_cnt, 1);

    // Nth output coincides with stop; discard of one.
    start_only(16'd3, 16'd1);
    clear_to_run();
    for (int k = 0; k < 4; k++) dec_pulse(16'h0700 + 16'(k), 16'h0800 + 16'(k), 8'h00, k == 3);
    repeat (4) tick();
    check("coinc_valid_cnt", valid_cnt, 3);
    check("coinc_done_cnt", done_cnt, 1);

    // Unlimited run past counter saturation, ended by stop.
    start_only(16'd0, 16'd0);
    clear_to_run();
    for (int k = 0; k < 70000; k++) begin
      vi = WIDTH'(k);
      dec_pulse(vi, ~vi, 8'h00);
    end
    tick();
    check("unlim_valid_cnt", valid_cnt, 70000);
    check("unlim_no_done", done_cnt, 0);
    check("unlim_busy", o_busy, 1);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    wait_done(5, "unlim_done_timeout");
    tick(); tick();
    check("unlim_done_cnt", done_cnt, 1);
    check("unlim_busy_after", o_busy, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
